// File: rtl/micro_seq_pkg.sv
// Shared definitions for the micro-program sequencer: microword field layout,
// op encoding and sequencer states.
package micro_seq_pkg;

  localparam int unsigned CTRL_MSB = 31;
  localparam int unsigned CTRL_LSB = 15;
  localparam int unsigned EOI_BIT  = 14;
  localparam int unsigned OP_MSB   = 13;
  localparam int unsigned OP_LSB   = 12;
  localparam int unsigned CSEL_MSB = 11;
  localparam int unsigned CSEL_LSB = 8;
  localparam int unsigned TGT_MSB  = 7;
  localparam int unsigned TGT_LSB  = 0;

  localparam logic [7:0] RESET_ADDR_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    OpSeq  = 2'b00,
    OpJmp  = 2'b01,
    OpCond = 2'b10,
    OpDisp = 2'b11
  } op_e;

  typedef enum logic {
    StFill = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/micro_next_addr.sv
// Combinational decode of the executing microword: picks the speculative fetch
// address, whether its word is taken, the next uPC and the execute/ready flags.
module micro_next_addr
  import micro_seq_pkg::*;
(
  input  logic [OP_MSB:0] uir_i,
  input  logic [7:0]      upc_i,
  input  logic [15:0]     cond_i,
  input  logic            opcode_valid_i,
  input  logic [7:0]      opcode_i,
  input  logic            run_i,
  output logic [7:0]      spec_addr_o,
  output logic            take_spec_o,
  output logic [7:0]      upc_next_o,
  output logic            exec_o,
  output logic            ready_o
);

  op_e  op;
  logic taken;

  always_comb begin
    op          = op_e'(uir_i[OP_MSB:OP_LSB]);
    taken       = cond_i[uir_i[CSEL_MSB:CSEL_LSB]];
    spec_addr_o = uir_i[TGT_MSB:TGT_LSB];
    take_spec_o = 1'b0;
    exec_o      = run_i;
    ready_o     = 1'b0;
    unique case (op)
      OpSeq:  take_spec_o = 1'b0;
      OpJmp:  take_spec_o = 1'b1;
      OpCond: take_spec_o = taken;
      OpDisp: begin
        spec_addr_o = opcode_i;
        take_spec_o = 1'b1;
        exec_o      = run_i & opcode_valid_i;
        ready_o     = run_i & opcode_valid_i;
      end
      default: take_spec_o = 1'b0;
    endcase
    // Wraps modulo 256 by width truncation.
    upc_next_o = take_spec_o ? spec_addr_o + 8'd1 : upc_i + 8'd1;
  end

endmodule

// File: rtl/micro_sequencer.sv
// Two-stage micro-program sequencer: uPC/uIR registers, FILL/RUN state and the
// reset > flush > stall priority; next-address decode lives in micro_next_addr.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter logic [7:0]  RESET_ADDR = RESET_ADDR_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_W-1:0]   micro_code_addr_out,
  input  logic [DATA_W-1:0]   micro_code_data_in,
  output logic [ADDR_W-1:0]   micro_code_addr_speculative_fetch_out,
  input  logic [DATA_W-1:0]   micro_code_data_speculative_fetch_in,
  input  logic [15:0]         cond_in,
  input  logic                stall_in,
  input  logic                flush_in,
  input  logic                opcode_valid_in,
  input  logic [7:0]          opcode_in,
  output logic                opcode_ready_out,
  output logic [16:0]         ctrl_out,
  output logic                ctrl_valid_out,
  output logic                eoi_out
);

  state_e      state_q;
  logic [7:0]  upc_q;
  logic [31:0] uir_q;
  logic [16:0] ctrl_q;
  logic        eoi_q;
  logic        ctrl_valid_q;

  logic        run;
  logic [7:0]  spec_addr;
  logic        take_spec;
  logic [7:0]  upc_next;
  logic        exec;
  logic        ready;

  assign run = (state_q == StRun) & ~stall_in & ~flush_in;

  micro_next_addr u_next_addr (
    .uir_i          (uir_q[OP_MSB:0]),
    .upc_i          (upc_q),
    .cond_i         (cond_in),
    .opcode_valid_i (opcode_valid_in),
    .opcode_i       (opcode_in),
    .run_i          (run),
    .spec_addr_o    (spec_addr),
    .take_spec_o    (take_spec),
    .upc_next_o     (upc_next),
    .exec_o         (exec),
    .ready_o        (ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StFill;
      upc_q        <= RESET_ADDR;
      uir_q        <= '0;
      ctrl_q       <= '0;
      eoi_q        <= 1'b0;
      ctrl_valid_q <= 1'b0;
    end else if (flush_in) begin
      state_q      <= StFill;
      upc_q        <= RESET_ADDR;
      ctrl_valid_q <= 1'b0;
    end else if (stall_in) begin
      ctrl_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StFill: begin
          uir_q        <= micro_code_data_in;
          upc_q        <= RESET_ADDR + 8'd1;
          state_q      <= StRun;
          ctrl_valid_q <= 1'b0;
        end
        StRun: begin
          if (exec) begin
            uir_q        <= take_spec ? micro_code_data_speculative_fetch_in
                                      : micro_code_data_in;
            upc_q        <= upc_next;
            ctrl_q       <= uir_q[CTRL_MSB:CTRL_LSB];
            eoi_q        <= uir_q[EOI_BIT];
            ctrl_valid_q <= 1'b1;
          end else begin
            ctrl_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= StFill;
          ctrl_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign micro_code_addr_out                   = upc_q;
  assign micro_code_addr_speculative_fetch_out = spec_addr;
  assign opcode_ready_out                      = ready;
  assign ctrl_out                              = ctrl_q;
  assign eoi_out                               = eoi_q;
  assign ctrl_valid_out                        = ctrl_valid_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a ROM model plus a per-cycle vector
// table, followed by a hand-written asynchronous reset sequence.
module tb_micro_sequencer;

  logic        clk;
  logic        rst;
  logic [7:0]  addr;
  logic [31:0] data;
  logic [7:0]  spec_addr;
  logic [31:0] spec_data;
  logic [15:0] cond;
  logic        stall;
  logic        flush;
  logic        opv;
  logic [7:0]  opc;
  logic        ready;
  logic [16:0] ctrl;
  logic        valid;
  logic        eoi;

  logic [31:0] rom [256];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [15:0] cond;
    logic        opv;
    logic [7:0]  opc;
    logic        chk_sa;
    logic [7:0]  exp_sa;
    logic        exp_ready;
    logic        exp_valid;
    logic [17:0] exp_ce;
    logic [7:0]  exp_upc;
  } vec_t;

  vec_t vecs[$];

  micro_sequencer dut (
    .clk                                   (clk),
    .rst                                   (rst),
    .micro_code_addr_out                   (addr),
    .micro_code_data_in                    (data),
    .micro_code_addr_speculative_fetch_out (spec_addr),
    .micro_code_data_speculative_fetch_in  (spec_data),
    .cond_in                               (cond),
    .stall_in                              (stall),
    .flush_in                              (flush),
    .opcode_valid_in                       (opv),
    .opcode_in                             (opc),
    .opcode_ready_out                      (ready),
    .ctrl_out                              (ctrl),
    .ctrl_valid_out                        (valid),
    .eoi_out                               (eoi)
  );

  assign data      = rom[addr];
  assign spec_data = rom[spec_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each word carries a ctrl/eoi signature unique to its own address.
  function automatic logic [17:0] ce(input logic [7:0] a);
    return {1'b1, a, a ^ 8'h5A, a[0]};
  endfunction

  function automatic logic [31:0] mk(input logic [7:0] a, input logic [1:0] op,
                                     input logic [3:0] csel, input logic [7:0] tgt);
    return {ce(a), op, csel, tgt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic fl, input logic [15:0] cd, input logic ov,
                     input logic [7:0] oc, input logic csa, input logic [7:0] esa,
                     input logic erdy, input logic evld, input logic [17:0] ece,
                     input logic [7:0] eupc);
    vec_t v;
    v.stall = st; v.flush = fl; v.cond = cd; v.opv = ov; v.opc = oc;
    v.chk_sa = csa; v.exp_sa = esa; v.exp_ready = erdy; v.exp_valid = evld;
    v.exp_ce = ece; v.exp_upc = eupc;
    vecs.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i] = mk(8'(i), 2'b00, 4'(i), ~8'(i));
    end
    rom[8'h05] = mk(8'h05, 2'b01, 4'h0, 8'h40);
    rom[8'h42] = mk(8'h42, 2'b01, 4'h0, 8'h10);
    rom[8'h10] = mk(8'h10, 2'b10, 4'h3, 8'h80);
    rom[8'h81] = mk(8'h81, 2'b01, 4'h0, 8'h10);
    rom[8'h11] = mk(8'h11, 2'b01, 4'h0, 8'h20);
    rom[8'h20] = mk(8'h20, 2'b11, 4'h0, 8'h55);
    rom[8'h9D] = mk(8'h9D, 2'b01, 4'h0, 8'hFF);

    rst = 1'b1; stall = 1'b0; flush = 1'b0; cond = '0; opv = 1'b0; opc = '0;

    //  st  fl  cond      ov  opc    csa  esa    rdy  vld  ce          upc
    add(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 0, 0, 18'h0,      8'h01); // FILL
    add(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 0, 1, ce(8'h00), 8'h02);
    add(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 0, 1, ce(8'h01), 8'h03);
    add(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 0, 1, ce(8'h02), 8'h04);
    add(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 0, 1, ce(8'h03), 8'h05);
    add(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 0, 1, ce(8'h04), 8'h06);
    add(0, 0, 16'h0000, 0, 8'h00, 1, 8'h40, 0, 1, ce(8'h05), 8'h41); // JMP 40
    add(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 0, 1, ce(8'h40), 8'h42);
    add(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 0, 1, ce(8'h41), 8'h43);
    add(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 0, 1, ce(8'h42), 8'h11); // JMP 10
    add(0, 0, 16'h0008, 0, 8'h00, 1, 8'h80, 0, 1, ce(8'h10), 8'h81); // COND taken
    add(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 0, 1, ce(8'h80), 8'h82);
    add(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 0, 1, ce(8'h81), 8'h11); // JMP 10
    add(0, 0, 16'hFFF7, 0, 8'h00, 0, 8'h00, 0, 1, ce(8'h10), 8'h12); // COND not taken
    add(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 0, 1, ce(8'h11), 8'h21); // JMP 20
    add(0, 0, 16'h0000, 0, 8'h33, 1, 8'h33, 0, 0, ce(8'h11), 8'h21); // DISP wait
    add(0, 0, 16'h0000, 0, 8'h9C, 0, 8'h00, 0, 0, ce(8'h11), 8'h21);
    add(0, 0, 16'h0000, 0, 8'h9C, 0, 8'h00, 0, 0, ce(8'h11), 8'h21);
    add(0, 0, 16'h0000, 1, 8'h9C, 1, 8'h9C, 1, 1, ce(8'h20), 8'h9D); // handshake
    add(0, 0, 16'h0000, 1, 8'h9C, 0, 8'h00, 0, 1, ce(8'h9C), 8'h9E);
    add(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 0, 1, ce(8'h9D), 8'h00); // JMP FF
    add(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 0, 1, ce(8'hFF), 8'h01); // wraps
    add(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 0, 1, ce(8'h00), 8'h02);
    add(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 0, 1, ce(8'h01), 8'h03);
    add(1, 0, 16'hFFFF, 1, 8'h00, 0, 8'h00, 0, 0, ce(8'h01), 8'h03); // stall
    add(1, 1, 16'hFFFF, 1, 8'h00, 0, 8'h00, 0, 0, ce(8'h01), 8'h00); // stall+flush
    add(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 0, 0, ce(8'h01), 8'h01); // FILL
    add(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 0, 1, ce(8'h00), 8'h02);
    add(0, 0, 16'h0000, 0, 8'h00, 0, 8'h00, 0, 1, ce(8'h01), 8'h03);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'(ctrl), 32'h0);
    chk("rst_eoi", 32'(eoi), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_upc", 32'(addr), 32'h0);

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].stall;
      flush = vecs[i].flush;
      cond  = vecs[i].cond;
      opv   = vecs[i].opv;
      opc   = vecs[i].opc;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(ready), 32'(vecs[i].exp_ready));
      if (vecs[i].chk_sa)
        chk($sformatf("v%0d_spec_addr", i), 32'(spec_addr), 32'(vecs[i].exp_sa));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_ctrl_eoi", i), 32'({ctrl, eoi}), 32'(vecs[i].exp_ce));
      chk($sformatf("v%0d_upc", i), 32'(addr), 32'(vecs[i].exp_upc));
    end

    // Asynchronous reset mid-chain must clear outputs without waiting for an edge.
    stall = 1'b0; flush = 1'b0; cond = '0; opv = 1'b0; opc = '0;
    #3;
    rst = 1'b1;
    #1;
    chk("async_valid", 32'(valid), 32'h0);
    chk("async_ctrl", 32'(ctrl), 32'h0);
    chk("async_upc", 32'(addr), 32'h0);
    chk("async_ready", 32'(ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_fill_valid", 32'(valid), 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(valid), 32'h1);
    chk("post_rst_ctrl_eoi", 32'({ctrl, eoi}), 32'(ce(8'h00)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
